// File: rtl/md5_chunk_loader.sv
// Collects a byte stream into one 512-bit MD5 block and appends MD5 padding
// (0x80 marker plus 64-bit little-endian bit length) for single-chunk messages.
module md5_chunk_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    input  logic [3:0]  gaddr,
    output logic [31:0] mdata,
    output logic        chunk_valid,
    input  logic        chunk_done,
    output logic [5:0]  msg_len,
    output logic        overflow
);

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_PAD   = 2'd2;
    localparam logic [1:0] ST_READY = 2'd3;

    // 55 bytes + 0x80 marker + 8 length bytes fill exactly 64 bytes.
    localparam logic [5:0] MAX_LEN = 6'd55;

    logic [1:0]  state;
    logic [31:0] words [16];
    logic [5:0]  len_q;
    logic        ovf_q;
    logic        accept;
    logic [3:0]  wr_word;
    logic [4:0]  wr_lane;

    assign in_ready    = (state == ST_FILL) || (state == ST_DRAIN);
    assign accept      = in_valid & in_ready;
    assign wr_word     = len_q[5:2];
    assign wr_lane     = {len_q[1:0], 3'b000};
    assign mdata       = words[gaddr];
    assign chunk_valid = (state == ST_READY);
    assign msg_len     = len_q;
    assign overflow    = ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FILL;
            len_q <= 6'd0;
            ovf_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                words[i] <= 32'd0;
            end
        end else begin
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        words[wr_word][wr_lane +: 8] <= in_data;
                        len_q <= len_q + 6'd1;
                        if (in_last) begin
                            state <= ST_PAD;
                        end else if (len_q == MAX_LEN - 6'd1) begin
                            state <= ST_DRAIN;
                            ovf_q <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (accept && in_last) begin
                        state <= ST_PAD;
                    end
                end
                ST_PAD: begin
                    // len_q <= 55 keeps the marker byte out of word 14.
                    words[wr_word][wr_lane +: 8] <= 8'h80;
                    words[14] <= {23'd0, len_q, 3'b000};
                    state <= ST_READY;
                end
                ST_READY: begin
                    if (chunk_done) begin
                        for (int i = 0; i < 16; i++) begin
                            words[i] <= 32'd0;
                        end
                        len_q <= 6'd0;
                        state <= ST_FILL;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

endmodule
